// File: rtl/mem_arbiter_if.sv
// Requester/memory bus of mem_arbiter; MEM_ARB_LOCK_EN adds the lock request lines.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [1:0]    req;
  logic [1:0]    we;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic [1:0]    gnt;
  logic [1:0]    rvalid;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;
  logic          mem_we;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;
`ifdef MEM_ARB_LOCK_EN
  logic [1:0]    lock;

  modport slave (
    input  req, we, addr0, addr1, wdata0, wdata1, mem_rd, lock,
    output gnt, rvalid, rdata0, rdata1, mem_we, mem_a, mem_wd
  );
  modport master (
    output req, we, addr0, addr1, wdata0, wdata1, mem_rd, lock,
    input  gnt, rvalid, rdata0, rdata1, mem_we, mem_a, mem_wd
  );
`else
  modport slave (
    input  req, we, addr0, addr1, wdata0, wdata1, mem_rd,
    output gnt, rvalid, rdata0, rdata1, mem_we, mem_a, mem_wd
  );
  modport master (
    output req, we, addr0, addr1, wdata0, wdata1, mem_rd,
    input  gnt, rvalid, rdata0, rdata1, mem_we, mem_a, mem_wd
  );
`endif
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port unified memory.
// Optional MEM_ARB_LOCK_EN lets the owner keep the memory across accesses.
module mem_arbiter #(
  parameter int          AW      = 32,
  parameter int          DW      = 32,
  parameter int unsigned RR_INIT = 0
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  localparam logic RR_INIT_B = RR_INIT[0];

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t        r_state;
  logic          r_owner;
  logic          r_rr;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [1:0]    r_gnt;
  logic [1:0]    r_rvalid;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;
  logic          w_any;
  logic          w_win;
`ifdef MEM_ARB_LOCK_EN
  logic          r_locked;
`endif

  always_comb begin
    w_any = |bus.req;
    w_win = (bus.req == 2'b11) ? r_rr : bus.req[1];
`ifdef MEM_ARB_LOCK_EN
    // A held lock hides the other requester entirely until released.
    if (r_locked) begin
      w_any = bus.req[r_owner];
      w_win = r_owner;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_owner  <= 1'b0;
      r_rr     <= RR_INIT_B;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_gnt    <= '0;
      r_rvalid <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
`ifdef MEM_ARB_LOCK_EN
      r_locked <= 1'b0;
`endif
    end else begin
      r_rvalid <= '0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_owner <= w_win;
            r_addr  <= w_win ? bus.addr1 : bus.addr0;
            r_wdata <= w_win ? bus.wdata1 : bus.wdata0;
            r_we    <= bus.we[w_win];
            r_gnt   <= w_win ? 2'b10 : 2'b01;
            r_state <= ACCESS;
          end
`ifdef MEM_ARB_LOCK_EN
          else if (r_locked && !bus.lock[r_owner]) begin
            r_locked <= 1'b0;
          end
`endif
        end
        ACCESS: begin
          if (!r_we) begin
            if (r_owner) r_rdata1 <= bus.mem_rd;
            else         r_rdata0 <= bus.mem_rd;
            r_rvalid[r_owner] <= 1'b1;
          end
          r_gnt   <= '0;
          r_state <= IDLE;
`ifdef MEM_ARB_LOCK_EN
          if (bus.lock[r_owner]) begin
            r_locked <= 1'b1;
          end else begin
            r_locked <= 1'b0;
            r_rr     <= ~r_owner;
          end
`else
          r_rr <= ~r_owner;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Write strobe decoded from state so an asynchronous reset kills it at once.
  assign bus.mem_we = (r_state == ACCESS) && r_we;
  assign bus.mem_a  = r_addr;
  assign bus.mem_wd = r_wdata;
  assign bus.gnt    = r_gnt;
  assign bus.rvalid = r_rvalid;
  assign bus.rdata0 = r_rdata0;
  assign bus.rdata1 = r_rdata1;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic vs a transaction model.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  mem_arbiter #(.AW(AW), .DW(DW), .RR_INIT(0)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [31:0] ram     [64];
  logic [31:0] exp_ram [64];
  assign bus.mem_rd = ram[bus.mem_a[7:2]];
  always @(posedge clk) if (bus.mem_we) ram[bus.mem_a[7:2]] = bus.mem_wd;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  bit          p_pend [2];
  bit          p_we   [2];
  bit          p_lock [2];
  logic [31:0] p_addr [2];
  logic [31:0] p_wd   [2];

  bit          m_busy;
  int          m_owner;
  bit          m_we_l;
  logic [31:0] m_addr_l, m_wd_l;
  logic [1:0]  m_gnt, m_rvalid;
  logic [31:0] m_rdata [2];
  int          m_turn;
  bit          m_locked;

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_we_l = 0; m_addr_l = '0; m_wd_l = '0;
    m_gnt = '0; m_rvalid = '0; m_rdata[0] = '0; m_rdata[1] = '0;
    m_turn = 0; m_locked = 0;
  endtask

  task automatic drive();
    bus.req    = {p_pend[1], p_pend[0]};
    bus.we     = {p_we[1], p_we[0]};
    bus.addr0  = p_addr[0];
    bus.addr1  = p_addr[1];
    bus.wdata0 = p_wd[0];
    bus.wdata1 = p_wd[1];
`ifdef MEM_ARB_LOCK_EN
    bus.lock   = {p_lock[1], p_lock[0]};
`endif
  endtask

  // One memory transaction at a time; whose turn it is flips after each finished access.
  task automatic model_edge(output int w);
    w = -1;
    m_rvalid = '0;
    if (m_busy) begin
      if (m_we_l) exp_ram[m_addr_l[7:2]] = m_wd_l;
      else begin
        m_rdata[m_owner] = exp_ram[m_addr_l[7:2]];
        m_rvalid[m_owner] = 1'b1;
      end
`ifdef MEM_ARB_LOCK_EN
      m_locked = p_lock[m_owner];
      if (!m_locked) m_turn = 1 - m_owner;
`else
      m_turn = 1 - m_owner;
`endif
      m_busy = 0;
      m_gnt = '0;
    end else begin
`ifdef MEM_ARB_LOCK_EN
      if (m_locked) begin
        if (p_pend[m_owner]) w = m_owner;
        else if (!p_lock[m_owner]) m_locked = 0;
      end else
`endif
      if (p_pend[0] && p_pend[1]) w = m_turn;
      else if (p_pend[0]) w = 0;
      else if (p_pend[1]) w = 1;
      if (w >= 0) begin
        m_busy = 1; m_owner = w; m_we_l = p_we[w];
        m_addr_l = p_addr[w]; m_wd_l = p_wd[w];
        m_gnt = 2'(1 << w);
        p_pend[w] = 0;
      end
    end
  endtask

  task automatic step(output int w);
    drive();
    @(posedge clk);
    model_edge(w);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      p_pend[i] = 0; p_we[i] = 0; p_lock[i] = 0; p_addr[i] = '0; p_wd[i] = '0;
    end
    drive();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      p_pend[i] = 0; p_we[i] = 0; p_lock[i] = 0; p_addr[i] = '0; p_wd[i] = '0;
    end
    drive();
    #12;
    n_checks++; if (bus.gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt got %b exp 00", bus.gnt); end
    n_checks++; if (bus.rvalid !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid got %b exp 00", bus.rvalid); end
    n_checks++; if (bus.rdata0 !== 32'h0) begin n_fail++; $display("FAIL reset_rdata0 got %h exp 0", bus.rdata0); end
    n_checks++; if (bus.rdata1 !== 32'h0) begin n_fail++; $display("FAIL reset_rdata1 got %h exp 0", bus.rdata1); end
    n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got %b exp 0", bus.mem_we); end
    n_checks++; if (bus.mem_a !== 32'h0) begin n_fail++; $display("FAIL reset_mem_a got %h exp 0", bus.mem_a); end
    n_checks++; if (bus.mem_wd !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wd got %h exp 0", bus.mem_wd); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single_read();
    int g;
    do_reset();
    p_pend[0] = 1; p_we[0] = 0; p_addr[0] = 32'h8;
    step(g);
    n_checks++; if (bus.gnt !== 2'b01) begin n_fail++; $display("FAIL rd_gnt got %b exp 01", bus.gnt); end
    n_checks++; if (bus.mem_a !== 32'h8) begin n_fail++; $display("FAIL rd_mem_a got %h exp 8", bus.mem_a); end
    n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL rd_mem_we got %b exp 0", bus.mem_we); end
    step(g);
    n_checks++; if (bus.gnt !== 2'b00) begin n_fail++; $display("FAIL rd_gnt_drop got %b exp 00", bus.gnt); end
    n_checks++; if (bus.rvalid !== 2'b01) begin n_fail++; $display("FAIL rd_rvalid got %b exp 01", bus.rvalid); end
    n_checks++; if (bus.rdata0 !== exp_ram[2]) begin n_fail++; $display("FAIL rd_rdata0 got %h exp %h", bus.rdata0, exp_ram[2]); end
    step(g);
    n_checks++; if (bus.rvalid !== 2'b00) begin n_fail++; $display("FAIL rd_rvalid_pulse got %b exp 00", bus.rvalid); end
  endtask

  task automatic test_write_readback();
    int g;
    logic [31:0] old1;
    old1 = m_rdata[1];
    p_pend[1] = 1; p_we[1] = 1; p_addr[1] = 32'h10; p_wd[1] = 32'hDEADBEEF;
    step(g);
    n_checks++; if (bus.gnt !== 2'b10) begin n_fail++; $display("FAIL wr_gnt got %b exp 10", bus.gnt); end
    n_checks++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL wr_mem_we got %b exp 1", bus.mem_we); end
    n_checks++; if (bus.mem_a !== 32'h10) begin n_fail++; $display("FAIL wr_mem_a got %h exp 10", bus.mem_a); end
    n_checks++; if (bus.mem_wd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_mem_wd got %h exp deadbeef", bus.mem_wd); end
    step(g);
    n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL wr_mem_we_drop got %b exp 0", bus.mem_we); end
    n_checks++; if (bus.rvalid !== 2'b00) begin n_fail++; $display("FAIL wr_no_rvalid got %b exp 00", bus.rvalid); end
    p_pend[0] = 1; p_we[0] = 0; p_addr[0] = 32'h10;
    step(g);
    step(g);
    n_checks++; if (bus.rvalid !== 2'b01) begin n_fail++; $display("FAIL wr_rb_rvalid got %b exp 01", bus.rvalid); end
    n_checks++; if (bus.rdata0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_rb_rdata0 got %h exp deadbeef", bus.rdata0); end
    n_checks++; if (bus.rdata1 !== old1) begin n_fail++; $display("FAIL wr_rb_rdata1_hold got %h exp %h", bus.rdata1, old1); end
  endtask

  task automatic test_contention();
    int g, k, gcyc;
    do_reset();
    k = 0; gcyc = 0;
    for (int i = 0; i < 2; i++) begin
      p_pend[i] = 1; p_we[i] = 0; p_addr[i] = 32'($urandom_range(0, 63) * 4);
    end
    for (int c = 0; c < 16; c++) begin
      step(g);
      if (bus.gnt !== 2'b00) gcyc++;
      if (g >= 0) begin
        n_checks++;
        if (bus.gnt !== 2'(1 << (k % 2))) begin
          n_fail++; $display("FAIL cont_alternate grant %0d got %b exp %b", k, bus.gnt, 2'(1 << (k % 2)));
        end
        k++;
        p_pend[g] = 1; p_addr[g] = 32'($urandom_range(0, 63) * 4);
      end
      n_checks++; if (bus.rdata0 !== m_rdata[0]) begin n_fail++; $display("FAIL cont_rdata0 got %h exp %h", bus.rdata0, m_rdata[0]); end
      n_checks++; if (bus.rdata1 !== m_rdata[1]) begin n_fail++; $display("FAIL cont_rdata1 got %h exp %h", bus.rdata1, m_rdata[1]); end
    end
    n_checks++; if (gcyc != 8) begin n_fail++; $display("FAIL cont_gnt_rate got %0d grant cycles exp 8", gcyc); end
  endtask

  task automatic test_back_to_back();
    int g, k;
    logic [31:0] b2b [3];
    logic [1:0] eg;
    b2b[0] = 32'h0; b2b[1] = 32'h4; b2b[2] = 32'h8;
    do_reset();
    k = 0;
    p_pend[0] = 1; p_we[0] = 0; p_addr[0] = b2b[0];
    for (int i = 0; i < 7; i++) begin
      step(g);
      eg = (i % 2 == 0 && i < 6) ? 2'b01 : 2'b00;
      n_checks++; if (bus.gnt !== eg) begin n_fail++; $display("FAIL b2b_gnt cycle %0d got %b exp %b", i, bus.gnt, eg); end
      if (eg != 2'b00) begin
        n_checks++;
        if (bus.mem_a !== b2b[i/2]) begin n_fail++; $display("FAIL b2b_addr cycle %0d got %h exp %h", i, bus.mem_a, b2b[i/2]); end
      end
      if (i % 2 == 1) begin
        n_checks++;
        if (bus.rdata0 !== exp_ram[b2b[(i-1)/2][7:2]])
          begin n_fail++; $display("FAIL b2b_rdata cycle %0d got %h exp %h", i, bus.rdata0, exp_ram[b2b[(i-1)/2][7:2]]); end
      end
      if (g == 0 && k < 2) begin
        k++; p_pend[0] = 1; p_addr[0] = b2b[k];
      end
    end
  endtask

  task automatic test_reset_mid_access();
    int g;
    do_reset();
    p_pend[1] = 1; p_we[1] = 1; p_addr[1] = 32'h30; p_wd[1] = 32'hCAFEF00D;
    step(g);
    n_checks++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL mid_mem_we_pre got %b exp 1", bus.mem_we); end
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL mid_mem_we_async got %b exp 0", bus.mem_we); end
    n_checks++; if (bus.gnt !== 2'b00) begin n_fail++; $display("FAIL mid_gnt got %b exp 00", bus.gnt); end
    @(posedge clk); #1;
    n_checks++; if (bus.rvalid !== 2'b00) begin n_fail++; $display("FAIL mid_rvalid got %b exp 00", bus.rvalid); end
    @(negedge clk);
    reset = 1'b1;
    exp_ram[12] = ram[12];
    for (int i = 0; i < 2; i++) begin
      p_pend[i] = 1; p_we[i] = 0; p_addr[i] = 32'(i * 4);
    end
    step(g);
    n_checks++; if (bus.gnt !== 2'b01) begin n_fail++; $display("FAIL mid_rr_init got %b exp 01", bus.gnt); end
    step(g);
    n_checks++; if (bus.rdata0 !== m_rdata[0]) begin n_fail++; $display("FAIL mid_rdata0 got %h exp %h", bus.rdata0, m_rdata[0]); end
    p_pend[0] = 0; p_pend[1] = 0;
  endtask

`ifdef MEM_ARB_LOCK_EN
  task automatic test_lock();
    int g;
    do_reset();
    p_pend[0] = 1; p_we[0] = 0; p_addr[0] = 32'h20; p_lock[0] = 1;
    p_pend[1] = 1; p_we[1] = 0; p_addr[1] = 32'h40;
    step(g);
    n_checks++; if (bus.gnt !== 2'b01) begin n_fail++; $display("FAIL lock_rd_gnt got %b exp 01", bus.gnt); end
    p_pend[0] = 1; p_we[0] = 1; p_wd[0] = 32'h12345678;
    step(g);
    n_checks++; if (bus.rdata0 !== exp_ram[8]) begin n_fail++; $display("FAIL lock_rd_data got %h exp %h", bus.rdata0, exp_ram[8]); end
    p_lock[0] = 0;
    step(g);
    n_checks++; if (bus.gnt !== 2'b01) begin n_fail++; $display("FAIL lock_wr_gnt got %b exp 01", bus.gnt); end
    n_checks++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL lock_wr_we got %b exp 1", bus.mem_we); end
    step(g);
    n_checks++; if (bus.gnt !== 2'b00) begin n_fail++; $display("FAIL lock_gap got %b exp 00", bus.gnt); end
    step(g);
    n_checks++; if (bus.gnt !== 2'b10) begin n_fail++; $display("FAIL lock_p1_gnt got %b exp 10", bus.gnt); end
    step(g);
    n_checks++; if (bus.rdata1 !== exp_ram[16]) begin n_fail++; $display("FAIL lock_p1_data got %h exp %h", bus.rdata1, exp_ram[16]); end
  endtask
`endif

  task automatic test_random();
    int g;
    logic ewe;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!p_pend[i] && $urandom_range(0, 2) == 0) begin
          p_pend[i] = 1; p_we[i] = $urandom_range(0, 1) == 1;
          p_addr[i] = 32'($urandom_range(0, 255)); p_wd[i] = $urandom;
        end
      end
      step(g);
      ewe = m_busy && m_we_l;
      n_checks++; if (bus.gnt !== m_gnt) begin n_fail++; $display("FAIL rnd_gnt cyc %0d got %b exp %b", cyc, bus.gnt, m_gnt); end
      n_checks++; if (bus.rvalid !== m_rvalid) begin n_fail++; $display("FAIL rnd_rvalid cyc %0d got %b exp %b", cyc, bus.rvalid, m_rvalid); end
      n_checks++; if (bus.rdata0 !== m_rdata[0]) begin n_fail++; $display("FAIL rnd_rdata0 cyc %0d got %h exp %h", cyc, bus.rdata0, m_rdata[0]); end
      n_checks++; if (bus.rdata1 !== m_rdata[1]) begin n_fail++; $display("FAIL rnd_rdata1 cyc %0d got %h exp %h", cyc, bus.rdata1, m_rdata[1]); end
      n_checks++; if (bus.mem_we !== ewe) begin n_fail++; $display("FAIL rnd_mem_we cyc %0d got %b exp %b", cyc, bus.mem_we, ewe); end
      if (m_busy) begin
        n_checks++; if (bus.mem_a !== m_addr_l) begin n_fail++; $display("FAIL rnd_mem_a cyc %0d got %h exp %h", cyc, bus.mem_a, m_addr_l); end
        n_checks++; if (bus.mem_wd !== m_wd_l) begin n_fail++; $display("FAIL rnd_mem_wd cyc %0d got %h exp %h", cyc, bus.mem_wd, m_wd_l); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      ram[i] = $urandom;
      exp_ram[i] = ram[i];
    end
    test_reset();
    test_single_read();
    test_write_readback();
    test_contention();
    test_back_to_back();
    test_reset_mid_access();
`ifdef MEM_ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
